// File: rtl/fifo_row_loader.sv
// fifo_row_loader: drains FIFO words one per cycle into packed rows of row_len lanes
// and hands each row to the PE array over a valid/ready handshake, num_rows rows per tile.
module fifo_row_loader #(
    parameter int data_size = 8,
    parameter int row_len   = 4,
    parameter int num_rows  = 16,
    parameter int cnt_w     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          fifo_empty,
    input  logic [data_size-1:0]          fifo_dout,
    output logic                          fifo_r_en,
    output logic [row_len*data_size-1:0]  row_data,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic                          busy,
    output logic                          done
);
    typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;
    localparam logic [cnt_w-1:0] row_max   = cnt_w'(row_len);
    localparam logic [cnt_w-1:0] row_last  = cnt_w'(row_len - 1);
    localparam logic [cnt_w-1:0] rows_last = cnt_w'(num_rows - 1);
    state_t state, state_nxt;
    logic [cnt_w-1:0] issued, captured, rows;
    logic pending, last_cap, accept;
    assign last_cap  = pending && captured == row_last;
    assign accept    = state == PRESENT && row_ready;
    assign fifo_r_en = state == FILL && !fifo_empty && issued < row_max;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? FILL : IDLE;
            FILL:    state_nxt = last_cap ? PRESENT : FILL;
            PRESENT: state_nxt = row_ready ? (rows == rows_last ? DONE : FILL) : PRESENT;
            DONE:    state_nxt = IDLE;
        endcase
    end
    // pending marks a read accepted last edge, so fifo_dout now carries that word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued    <= '0;
            captured  <= '0;
            rows      <= '0;
            pending   <= 1'b0;
            row_data  <= '0;
            row_valid <= 1'b0;
        end else begin
            pending <= fifo_r_en;
            if (fifo_r_en) issued <= issued + 1'b1;
            if (pending) begin
                for (int i = 0; i < row_len; i++)
                    if (captured == cnt_w'(i)) row_data[i*data_size +: data_size] <= fifo_dout;
                captured <= captured + 1'b1;
            end
            if (last_cap) row_valid <= 1'b1;
            if (state == IDLE && start) begin
                issued   <= '0;
                captured <= '0;
                rows     <= '0;
            end
            if (accept) begin
                row_valid <= 1'b0;
                issued    <= '0;
                captured  <= '0;
                if (rows != rows_last) rows <= rows + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_row_loader.sv
// tb_fifo_row_loader: scoreboard bench; FIFO words queued on write, rows compared on handshake.
module tb_fifo_row_loader;
    localparam int data_size = 8;
    localparam int row_len   = 4;
    localparam int num_rows  = 2;
    localparam int cnt_w     = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic fifo_empty = 1'b1;
    logic row_ready = 1'b0;
    logic [data_size-1:0] fifo_dout = '0;
    logic fifo_r_en, row_valid, busy, done;
    logic [row_len*data_size-1:0] row_data, exp_row, held;
    logic [data_size-1:0] fifo_q[$], sb_q[$];
    int checks = 0, errors = 0, cyc = 0;
    int ren_cnt = 0, row_cnt = 0, done_cnt = 0, rise_cyc = -1;
    logic prev_valid = 1'b0;
    fifo_row_loader #(.data_size(data_size), .row_len(row_len), .num_rows(num_rows), .cnt_w(cnt_w)) dut (
        .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_r_en(fifo_r_en), .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    // FIFO read port model: data appears the cycle after an accepted read
    always @(posedge clk) begin
        cyc++;
        if (fifo_r_en && fifo_q.size() > 0) begin
            fifo_dout  <= fifo_q.pop_front();
            fifo_empty <= fifo_q.size() == 0;
        end
    end
    always @(negedge clk) begin
        if (fifo_r_en) begin
            ren_cnt++;
            if (fifo_empty) check("ren_while_empty", 1, 0);
        end
        if (row_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
        prev_valid = row_valid;
        if (row_valid && row_ready) begin
            row_cnt++;
            if (sb_q.size() < row_len) check("sb_underrun", sb_q.size(), row_len);
            else begin
                for (int i = 0; i < row_len; i++) exp_row[i*data_size +: data_size] = sb_q.pop_front();
                check("row", row_data, exp_row);
            end
        end
        if (done) done_cnt++;
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic fifo_write(input logic [data_size-1:0] w);
        fifo_q.push_back(w);
        sb_q.push_back(w);
        fifo_empty = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask
    task automatic clear_counts();
        ren_cnt = 0;
        row_cnt = 0;
        done_cnt = 0;
        rise_cyc = -1;
    endtask
    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (done_cnt < 1 && n < max_cyc) begin
            tick(1);
            n++;
        end
        check("done_seen", done_cnt >= 1, 1);
    endtask
    task automatic write_seq(input logic [data_size-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_write(base + data_size'(i));
    endtask
    initial begin
        int s, n;
        logic stable;
        tick(3);
        write_seq(8'h01, 8);
        check("rst_valid", row_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", fifo_r_en, 0);
        check("rst_data", row_data, 0);
        reset = 1'b1;
        clear_counts();
        tick(20);
        check("idle_ren", ren_cnt, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", row_valid, 0);
        // basic tile: lane 0 gets the first word, row_valid rises row_len+1 edges after start
        row_ready = 1'b1;
        clear_counts();
        s = cyc + 1;
        pulse_start();
        wait_done(100);
        tick(3);
        check("basic_latency", rise_cyc - s, row_len + 1);
        check("basic_ren", ren_cnt, 8);
        check("basic_rows", row_cnt, num_rows);
        check("basic_done", done_cnt, 1);
        check("basic_busy", busy, 0);
        // backpressure
        row_ready = 1'b0;
        clear_counts();
        write_seq(8'h41, 8);
        pulse_start();
        n = 0;
        while (!row_valid && n < 50) begin
            tick(1);
            n++;
        end
        check("bp_valid", row_valid, 1);
        held = row_data;
        stable = 1'b1;
        repeat (7) begin
            tick(1);
            if (!row_valid || row_data !== held || fifo_r_en) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_held_rows", row_cnt, 0);
        check("bp_held_ren", ren_cnt, 4);
        row_ready = 1'b1;
        tick(1);
        check("bp_accept", row_cnt, 1);
        check("bp_drop", row_valid, 0);
        wait_done(100);
        check("bp_rows", row_cnt, num_rows);
        // empty stall mid-row
        clear_counts();
        write_seq(8'h01, 2);
        pulse_start();
        tick(10);
        check("stall_ren", ren_cnt, 2);
        check("stall_valid", row_valid, 0);
        check("stall_busy", busy, 1);
        write_seq(8'h03, 2);
        write_seq(8'h05, 4);
        wait_done(100);
        check("stall_rows", row_cnt, num_rows);
        check("stall_ren_total", ren_cnt, 8);
        // start while busy is ignored
        clear_counts();
        write_seq(8'h81, 8);
        pulse_start();
        tick(2);
        pulse_start();
        wait_done(100);
        tick(5);
        check("rebusy_rows", row_cnt, num_rows);
        check("rebusy_done", done_cnt, 1);
        check("rebusy_ren", ren_cnt, 8);
        check("rebusy_busy", busy, 0);
        // async reset after two accepted reads
        clear_counts();
        write_seq(8'h31, 8);
        pulse_start();
        tick(2);
        check("ar_ren_before", ren_cnt, 2);
        reset = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_valid", row_valid, 0);
        check("ar_data", row_data, 0);
        check("ar_ren", fifo_r_en, 0);
        check("ar_done", done, 0);
        tick(2);
        reset = 1'b1;
        void'(sb_q.pop_front());
        void'(sb_q.pop_front());
        write_seq(8'h39, 2);
        clear_counts();
        pulse_start();
        wait_done(100);
        check("ar_rows", row_cnt, num_rows);
        check("ar_ren_total", ren_cnt, 8);
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/fifo_row_loader.md
Name: fifo_row_loader

Overview:
- Read-side consumer of the activation/weight FIFO.
- Drains the FIFO one word per cycle and packs row_len consecutive words into one wide row.
- Presents each row to the PE array with a valid/ready handshake; repeats for num_rows rows per tile.
- Sits between the FIFO's read port and the systolic array input registers, and runs on the FIFO's read clock.

Parameters:
- data_size, 8, width of one FIFO word in bits
- row_len, 4, words packed per output row (PE lanes); >= 1
- num_rows, 16, rows per tile before done; >= 1
- cnt_w, 8, width of the internal word and row counters; must hold row_len and num_rows

Ports:
- clk  input  1  clock, same as FIFO r_clk
- reset  input  1  asynchronous, active-low reset
- start  input  1  1-cycle pulse that begins a tile; ignored unless idle
- fifo_empty  input  1  FIFO empty flag (registered in FIFO)
- fifo_dout  input  data_size  FIFO dataOut; valid the cycle after an accepted read
- fifo_r_en  output  1  FIFO read enable
- row_data  output  row_len*data_size  packed row; lane i = bits [i*data_size +: data_size]
- row_valid  output  1  row_data holds a complete row
- row_ready  input  1  PE array accepts the row
- busy  output  1  high in any state other than IDLE
- done  output  1  1-cycle pulse after the last row of the tile is accepted

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low.
- Reset values: state=IDLE; all counters=0; pending=0; row_data=0; row_valid=0; busy=0; done=0; fifo_r_en=0.
- Reset mid-operation aborts immediately. FIFO words already read are discarded, and upstream reclears the FIFO.

States:
- IDLE: start=1 -> FILL, clearing issued, captured and rows counters. start is ignored in every other state.
- FILL:
  - fifo_r_en = (state==FILL) & ~fifo_empty & (issued < row_len). This is combinational from registered state and fifo_empty.
  - Accepted read = fifo_r_en at a rising edge. On that edge: issued++ and pending<=1; otherwise pending<=0.
  - When pending=1, fifo_dout is captured into lane[captured], then captured++.
  - Lane 0 gets the first word read (LSBs).
  - When the capture of word row_len-1 happens: go to PRESENT and set row_valid<=1 on that same edge.
- PRESENT:
  - row_valid=1 and row_data held stable; fifo_r_en=0.
  - row_ready=1 at the edge: row_valid<=0, issued<=0, captured<=0.
    - If rows==num_rows-1: go to DONE.
    - Otherwise: rows++ and go to FILL.
  - row_ready=0: hold indefinitely, with no timeout.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE (busy=0 next cycle).

Timing and stalls:
- Latency: with the FIFO non-empty, start is sampled at edge k and reads are accepted at edges k+1..k+row_len. row_valid rises after edge k+row_len+1. Throughput is 1 word/cycle while filling.
- fifo_empty rising mid-row stalls issue. Counters and captured lanes hold, and an already-pending capture still completes. Issue resumes when empty falls.
- fifo_r_en is never asserted while fifo_empty=1, and never more than row_len times per row.
- row_ready while row_valid=0 has no effect.

Arithmetic:
- Counters are unsigned cnt_w bits and never wrap within a tile. rows compares against num_rows-1.
- No data transformation: row_data lanes are bit-exact FIFO words.

Test Plan:
- Reset/idle: hold reset=0, then release with no start -> all outputs 0, fifo_r_en never asserted for 20 cycles.
- Basic tile (row_len=4, num_rows=2): FIFO preloaded with 0x01..0x08, start at cycle 0, row_ready=1.
  - Row 0: row_valid at cycle 5 with row_data=0x04030201.
  - Row 1: row_data=0x08070605.
  - done pulses once; exactly 8 fifo_r_en cycles.
- Empty stall: FIFO holds 2 words, 2 more are written 10 cycles later -> fifo_r_en=0 while empty, no spurious capture; row_data=0x04030201 once the words arrive.
- Backpressure: row_ready=0 for 7 cycles after row_valid -> row_valid and row_data stable, fifo_r_en=0; accepted on the first cycle row_ready=1.
- Start while busy: pulse start again mid-FILL -> ignored, tile still yields exactly num_rows rows and one done.
- Async reset mid-row: assert reset after 2 accepted reads -> outputs return to reset values without waiting for clk; a new start reads from the next FIFO word.
